spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter DATA_W, default 4: transfer word width in bits; matches the 4-bit LED shift chain of the SPI slave.
REQ-002 Parameter CLK_DIV, default 4: sclk half-period in clk cycles; legal range 1..255.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to transfer tx_data; sampled only in IDLE.
REQ-006 tx_data  input  DATA_W  word to send, MSB first; captured on the accepting clk edge.
REQ-007 busy  output  1  high whenever the FSM is not in IDLE.
REQ-008 done  output  1  one-cycle pulse marking the end of a transfer.
REQ-009 rx_data  output  DATA_W  word received on miso; held until the next done.
REQ-010 sclk  output  1  serial clock to the slave; idles low.
REQ-011 mosi  output  1  serial data to the slave.
REQ-012 cs  output  1  chip select, active-high, because the slave gates MOSI with CS.
REQ-013 miso  input  1  serial data from the slave.

Function
REQ-014 sclk, mosi, cs, busy and done SHALL be driven directly from flops, with no combinational path from inputs.
REQ-015 FSM states SHALL be IDLE, LEAD, SCLK_HI, SCLK_LO, TRAIL and DONE.
REQ-016 IDLE: if start=1, the FSM SHALL capture tx_data into the shift register, load the bit counter with DATA_W-1 and enter LEAD; otherwise it stays in IDLE.
REQ-017 LEAD SHALL last CLK_DIV cycles with cs=1, sclk=0 and mosi=MSB, then enter SCLK_HI.
REQ-018 SCLK_HI SHALL last CLK_DIV cycles with sclk=1, and SHALL shift miso into the rx shift register LSB-side on the clk edge that ends the phase.
REQ-019 On leaving SCLK_HI: if the bit counter is 0, the FSM SHALL enter TRAIL; otherwise it SHALL decrement the counter, present the next bit on mosi and enter SCLK_LO.
REQ-020 SCLK_LO SHALL last CLK_DIV cycles with sclk=0, then enter SCLK_HI.
REQ-021 mosi SHALL change only while sclk=0, and at least CLK_DIV cycles before the next rising sclk edge, because the slave samples on rising sclk.
REQ-022 TRAIL SHALL last CLK_DIV cycles with cs=1 and sclk=0, then enter DONE.
REQ-023 DONE SHALL last 1 cycle with cs=0, done=1 and rx_data loaded from the rx shift register, then return to IDLE.
REQ-024 Latency from the start edge to the done cycle SHALL be (2*DATA_W+1)*CLK_DIV+1 cycles: 37 for the default parameters.
REQ-025 start while busy=1, including the DONE cycle, SHALL be ignored; there is no queueing.
REQ-026 A start in the first IDLE cycle after DONE SHALL be accepted, giving back-to-back transfers with cs low for exactly 2 cycles between them.
REQ-027 Changes on tx_data after the accepting edge SHALL have no effect on the word in flight.
REQ-028 The phase counter SHALL count CLK_DIV-1 down to 0, reload on every phase entry, and never wrap while in IDLE.

Reset
REQ-029 rst=0 SHALL force, asynchronously, state=IDLE, sclk=0, cs=0, mosi=0, busy=0, done=0, rx_data=0, and clear all counters and shift registers.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer with no done pulse; after release the block SHALL accept a new start normally.

Structure
REQ-031 A shared package spi_pkg SHALL hold the state enum spi_state_t and the default DATA_W and CLK_DIV constants.
REQ-032 One sub-module, spi_clk_div, SHALL implement the reloadable phase counter and output a one-cycle phase_end tick.

Verification
REQ-033 The bench SHALL apply tx_data=4'b1011 with start, spi_master wired to SPI_slave (slave rst tied inactive), and check that slave leds=4'b1011 when done pulses at cycle 37.
REQ-034 The bench SHALL apply loopback (miso=mosi) with tx_data=4'b0110 and check that rx_data=4'b0110 in the cycle after done.
REQ-035 The bench SHALL pulse start with tx_data=4'b1111 at cycle 10 of a 4'b0001 transfer and check that only one done occurs, with rx_data equal to the loopback of 4'b0001.
REQ-036 The bench SHALL assert rst=0 during the second SCLK_HI phase and check that cs=0, sclk=0 and busy=0 immediately, that no done is produced, and that the next transfer completes in 37 cycles.
REQ-037 The bench SHALL use CLK_DIV=1 with back-to-back starts and check done at cycle 10 of each transfer, with cs low for exactly 2 cycles between transfers.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI master.
package spi_pkg;

    // Default word width matches the 4-bit LED shift chain on the slave.
    localparam int unsigned DefDataW  = 4;
    // Default sclk half-period in clk cycles.
    localparam int unsigned DefClkDiv = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StSclkHi,
        StSclkLo,
        StTrail,
        StDone
    } spi_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Reloadable phase counter: counts CLK_DIV-1 down to 0 and flags the last cycle of a phase.
module spi_clk_div import spi_pkg::*; #(
    parameter int unsigned CLK_DIV = DefClkDiv
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic phase_end_o
);

    localparam logic [7:0] Reload = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    // Reload on phase entry, otherwise count down and park at zero (no wrap).
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = Reload;
        end else if (en_i && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign phase_end_o = en_i && (cnt_q == 8'd0);

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0, MSB first, active-high chip select; all pin outputs come from flops.
module spi_master import spi_pkg::*; #(
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned CLK_DIV = DefClkDiv
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              miso_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              sclk_o,
    output logic              mosi_o,
    output logic              cs_o
);

    localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

    spi_state_t        state_q, state_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [DATA_W-1:0] tx_shifted;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic              mosi_q, mosi_d;
    logic              sclk_q, cs_q, busy_q, done_q;
    logic              phase_load, phase_end, timed;

    assign timed = (state_q == StLead) || (state_q == StSclkHi) ||
                   (state_q == StSclkLo) || (state_q == StTrail);
    assign tx_shifted = tx_sr_q << 1;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (phase_load),
        .en_i        (timed),
        .phase_end_o (phase_end)
    );

    // Next-state, shift-register and bit-counter logic.
    always_comb begin
        state_d    = state_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        bit_cnt_d  = bit_cnt_q;
        mosi_d     = mosi_q;
        phase_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    tx_sr_d    = tx_data_i;
                    rx_sr_d    = '0;
                    mosi_d     = tx_data_i[DATA_W-1];
                    bit_cnt_d  = BitLast;
                    phase_load = 1'b1;
                    state_d    = StLead;
                end
            end
            StLead: begin
                if (phase_end) begin
                    phase_load = 1'b1;
                    state_d    = StSclkHi;
                end
            end
            StSclkHi: begin
                if (phase_end) begin
                    rx_sr_d    = (rx_sr_q << 1) | DATA_W'(miso_i);
                    phase_load = 1'b1;
                    if (bit_cnt_q == '0) begin
                        state_d = StTrail;
                    end else begin
                        // Next bit goes out as sclk falls, a full phase before the next rise.
                        bit_cnt_d = bit_cnt_q - 1'b1;
                        tx_sr_d   = tx_shifted;
                        mosi_d    = tx_shifted[DATA_W-1];
                        state_d   = StSclkLo;
                    end
                end
            end
            StSclkLo: begin
                if (phase_end) begin
                    phase_load = 1'b1;
                    state_d    = StSclkHi;
                end
            end
            StTrail: begin
                if (phase_end) begin
                    rx_data_d = rx_sr_q;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, datapath and registered pin outputs (decoded from the next state).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            mosi_q    <= 1'b0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            bit_cnt_q <= bit_cnt_d;
            mosi_q    <= mosi_d;
            sclk_q    <= (state_d == StSclkHi);
            cs_q      <= (state_d != StIdle) && (state_d != StDone);
            busy_q    <= (state_d != StIdle);
            done_q    <= (state_d == StDone);
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rx_data_o = rx_data_q;
    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;
    assign cs_o      = cs_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: default instance with a behavioural LED slave and
// selectable miso source, plus a CLK_DIV=1 instance in loopback for back-to-back transfers.
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance.
    logic       rst_n, start, miso, busy, done, sclk, mosi, cs;
    logic [3:0] tx, rx;
    // CLK_DIV=1 instance.
    logic       rst1_n, start1, busy1, done1, sclk1, mosi1, cs1;
    logic [3:0] tx1, rx1;

    int n_cmp = 0;
    int n_err = 0;

    spi_master u_dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start),
        .tx_data_i (tx),
        .miso_i    (miso),
        .busy_o    (busy),
        .done_o    (done),
        .rx_data_o (rx),
        .sclk_o    (sclk),
        .mosi_o    (mosi),
        .cs_o      (cs)
    );

    spi_master #(
        .DATA_W  (4),
        .CLK_DIV (1)
    ) u_dut1 (
        .clk_i     (clk),
        .rst_ni    (rst1_n),
        .start_i   (start1),
        .tx_data_i (tx1),
        .miso_i    (mosi1),
        .busy_o    (busy1),
        .done_o    (done1),
        .rx_data_o (rx1),
        .sclk_o    (sclk1),
        .mosi_o    (mosi1),
        .cs_o      (cs1)
    );

    // Behavioural LED slave: shifts mosi in on rising sclk while selected; its reset is inactive.
    logic [3:0] leds = 4'd0;
    always @(posedge sclk) if (cs) leds <= {leds[2:0], mosi};

    // Miso source: loopback, or the bits of miso_word MSB first, advancing after each sclk fall.
    logic       loop_mode = 1'b1;
    logic [3:0] miso_word = 4'd0;
    logic [2:0] fall_cnt = 3'd0;
    logic       sclk_prev = 1'b0;
    logic       mosi_prev = 1'b0;
    int         viol = 0;
    always @(negedge clk) begin
        if (!cs) fall_cnt <= 3'd0;
        else if (sclk_prev && !sclk) fall_cnt <= fall_cnt + 3'd1;
        if (rst_n && (mosi !== mosi_prev) && sclk) viol <= viol + 1;
        sclk_prev <= sclk;
        mosi_prev <= mosi;
    end
    assign miso = loop_mode ? mosi :
                  ((fall_cnt < 3'd4) ? miso_word[2'd3 - fall_cnt[1:0]] : 1'b0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transfer on the default instance, started at a negedge; expected values come from the
    // rules: latency (2*4+1)*4+1, rx = tx (loopback) or the miso word, slave LEDs = tx.
    task automatic do_xfer(input logic [3:0] w, input logic lb, input logic [3:0] mw,
                           input string tag);
        int         lat;
        logic [3:0] exp_rx;
        exp_rx    = lb ? w : mw;
        loop_mode = lb;
        miso_word = mw;
        start     = 1'b1;
        tx        = w;
        @(negedge clk);
        start = 1'b0;
        tx    = 4'($urandom);
        lat   = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, 37);
        chk({tag, " cs in done"}, cs, 0);
        chk({tag, " busy in done"}, busy, 1);
        chk({tag, " leds"}, leds, w);
        chk({tag, " rx in done"}, rx, exp_rx);
        @(negedge clk);
        chk({tag, " done one cycle"}, done, 0);
        chk({tag, " idle after done"}, busy, 0);
        chk({tag, " rx held"}, rx, exp_rx);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int         n_done;
        int         idx;
        int         cs_run;
        logic       seen_cs;
        logic [3:0] words [4];
        logic [3:0] w;

        rst_n  = 1'b0;
        rst1_n = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        tx     = 4'd0;
        tx1    = 4'd0;
        #12;
        chk("reset cs", cs, 0);
        chk("reset sclk", sclk, 0);
        chk("reset mosi", mosi, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset rx", rx, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        rst1_n = 1'b1;
        repeat (2) @(negedge clk);

        do_xfer(4'b1011, 1'b1, 4'd0, "slave 1011");
        do_xfer(4'b0110, 1'b1, 4'd0, "loop 0110");

        for (int i = 0; i < 6; i++) begin
            do_xfer(4'($urandom), 1'($urandom_range(0, 1)), 4'($urandom), "random");
        end

        // Start pulse with a different word mid-transfer must be ignored.
        loop_mode = 1'b1;
        start     = 1'b1;
        tx        = 4'b0001;
        @(negedge clk);
        n_done = 0;
        for (int c = 1; c < 60; c++) begin
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    chk("ignore start latency", c, 37);
                    chk("ignore start rx", rx, 4'b0001);
                end
            end
            if (c == 10) begin
                start = 1'b1;
                tx    = 4'b1111;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("ignore start done count", n_done, 1);

        // Asynchronous reset during the second sclk-high phase.
        start = 1'b1;
        tx    = 4'($urandom);
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        chk("abort in sclk high", sclk, 1);
        rst_n = 1'b0;
        #1;
        chk("abort cs", cs, 0);
        chk("abort sclk", sclk, 0);
        chk("abort busy", busy, 0);
        n_done = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort no done", n_done, 0);
        do_xfer(4'($urandom), 1'b1, 4'd0, "after abort");

        chk("mosi only changes with sclk low", viol, 0);

        // CLK_DIV=1, start held high: transfers accepted in each first idle cycle.
        for (int i = 0; i < 4; i++) words[i] = 4'($urandom);
        start1  = 1'b1;
        tx1     = words[0];
        idx     = 0;
        cs_run  = 0;
        seen_cs = 1'b0;
        for (int k = 1; k < 100 && idx < 4; k++) begin
            @(negedge clk);
            if (!cs1) begin
                cs_run++;
            end else begin
                if (seen_cs && cs_run > 0) chk("b2b cs low gap", cs_run, 2);
                cs_run  = 0;
                seen_cs = 1'b1;
            end
            if (done1) begin
                chk("b2b done cycle", k, 10 + 11 * idx);
                chk("b2b rx", rx1, words[idx]);
                idx++;
                if (idx < 4) tx1 = words[idx];
                else start1 = 1'b0;
            end
        end
        chk("b2b transfer count", idx, 4);

        w = 4'd0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
